// File: rtl/reset_sequencer.sv
// Ordered reset-release controller: holds all stage resets for HOLD_CYCLES, then
// releases stages one at a time, each gated by the previous stage's ack plus a settle delay.
module reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_DELAY = 8,
  parameter int unsigned ACK_TIMEOUT = 255,
  localparam int unsigned IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sw_reset_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic                  timeout_err,
  output logic [IW-1:0]         fail_stage
);

  localparam int unsigned HD_MAX  = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
  localparam int unsigned CNT_MAX = (HD_MAX > ACK_TIMEOUT) ? HD_MAX : ACK_TIMEOUT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_ASSERT = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [IW-1:0]         fail_q, fail_d;

  // State and output registers; synchronous reset restarts the whole sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ASSERT;
      idx_q   <= '0;
      cnt_q   <= '0;
      rst_q   <= '1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one edge ahead.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    fail_d  = fail_q;
    case (state_q)
      S_ASSERT: begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          rst_d[0] = 1'b0;
          cnt_d    = '0;
          state_d  = S_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        // An ack on the final timeout cycle still counts.
        if (stage_ack[idx_q]) begin
          cnt_d = '0;
          if (idx_q == IW'(NUM_STAGES - 1)) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_SETTLE;
          end
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          state_d      = S_ERROR;
          fail_d       = idx_q;
          rst_d[idx_q] = 1'b1;
          busy_d       = 1'b0;
          err_d        = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == CW'(STAGE_DELAY - 1)) begin
          idx_d        = idx_q + IW'(1);
          rst_d[idx_d] = 1'b0;
          cnt_d        = '0;
          state_d      = S_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE, S_ERROR: begin
        if (sw_reset_req) begin
          state_d = S_ASSERT;
          idx_d   = '0;
          cnt_d   = '0;
          rst_d   = '1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          fail_d  = '0;
        end
      end
      default: begin
        state_d = S_ASSERT;
        idx_d   = '0;
        cnt_d   = '0;
        rst_d   = '1;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        err_d   = 1'b0;
        fail_d  = '0;
      end
    endcase
  end

  assign stage_rst   = rst_q;
  assign seq_busy    = busy_q;
  assign seq_done    = done_q;
  assign timeout_err = err_q;
  assign fail_stage  = fail_q;

endmodule
